// File: rtl/aes_sbox_sched.sv
// ============================================================================
// Module      : aes_sbox_sched
// Description : Time-multiplexed AES S-box server. Up to NREQ requesters
//               submit 32-bit words; a single 8-bit S-box substitutes the
//               four bytes one per cycle and the result is returned on a
//               valid/ready port tagged with the requester index.
//               Optional feature macro: AES_SBOX_SCHED_PRIO_EN gives
//               requester 0 strict priority over the round-robin pool.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry x lives at bits [2047-8x -: 8], so row 0 of the classic table
    // sits in the most significant 128 bits.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Low bit of entry x is 8*(255-x) = 8*~x.
    assign o_byte = c_SBOX[{~i_byte, 3'b000} +: 8];

endmodule

module aes_sbox_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_word,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_word,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);

    localparam logic [1:0]     c_IDLE = 2'd0;
    localparam logic [1:0]     c_SUB  = 2'd1;
    localparam logic [1:0]     c_RESP = 2'd2;

    localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] c_ONE  = IDW'(1);
    localparam logic [IDW:0]   c_NREQ = (IDW + 1)'(NREQ);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_cnt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [31:0]     r_operand;
    logic [31:0]     r_result;

    logic [NREQ-1:0] w_cand;
    logic [IDW-1:0]  w_start;
    logic [NREQ-1:0] w_rot;
    logic [IDW-1:0]  w_off;
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_rr_grant;
    logic            w_rr_found;
    logic [IDW-1:0]  w_grant;
    logic            w_found;
    logic            w_upd_ptr;
    logic            w_accept;
    logic [7:0]      w_sbox_out;

    // Requester 0 is taken out of the round-robin pool when it has priority.
`ifdef AES_SBOX_SCHED_PRIO_EN
    assign w_cand = {req_valid[NREQ-1:1], 1'b0};
`else
    assign w_cand = req_valid;
`endif

    // Round-robin search: rotate the candidates so the slot after ptr is bit 0,
    // take the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        w_start    = (r_ptr == c_LAST) ? '0 : r_ptr + c_ONE;
        w_rot      = (w_cand >> w_start) | (w_cand << (c_NREQ - {1'b0, w_start}));
        w_rr_found = |w_rot;
        w_off      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = i[IDW-1:0];
            end
        end
        w_sum      = {1'b0, w_start} + {1'b0, w_off};
        w_rr_grant = (w_sum >= c_NREQ) ? IDW'(w_sum - c_NREQ) : IDW'(w_sum);
    end

    // Final grant selection; a priority grant to requester 0 leaves ptr alone.
    always_comb begin
`ifdef AES_SBOX_SCHED_PRIO_EN
        if (req_valid[0]) begin
            w_grant   = '0;
            w_found   = 1'b1;
            w_upd_ptr = 1'b0;
        end else begin
            w_grant   = w_rr_grant;
            w_found   = w_rr_found;
            w_upd_ptr = 1'b1;
        end
`else
        w_grant   = w_rr_grant;
        w_found   = w_rr_found;
        w_upd_ptr = 1'b1;
`endif
    end

    assign w_accept = (r_state == c_IDLE) && w_found;

    // The one shared S-box always looks at the operand byte selected by cnt.
    aes_sbox u_sbox (
        .i_byte (r_operand[{r_cnt, 3'b000} +: 8]),
        .o_byte (w_sbox_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SUB on accept, four SUB cycles, RESP until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept)       w_state_nxt = c_SUB;
            c_SUB:  if (r_cnt == 2'd3)  w_state_nxt = c_RESP;
            c_RESP: if (resp_ready)     w_state_nxt = c_IDLE;
            default:                    w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs: ready is combinational in the accept cycle, response from registers.
    always_comb begin
        req_ready  = w_accept ? ({{(NREQ-1){1'b0}}, 1'b1} << w_grant) : '0;
        resp_valid = (r_state == c_RESP);
        resp_word  = r_result;
        resp_id    = r_id;
        busy       = (r_state != c_IDLE);
    end

    // Datapath: capture on accept, one substituted byte per SUB cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= 2'd0;
            r_ptr     <= c_LAST;
            r_id      <= '0;
            r_operand <= 32'h0;
            r_result  <= 32'h0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_operand <= req_word[{w_grant, 5'b00000} +: 32];
                        r_id      <= w_grant;
                        r_cnt     <= 2'd0;
                        if (w_upd_ptr) begin
                            r_ptr <= w_grant;
                        end
                    end
                end
                c_SUB: begin
                    r_result[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
                    r_cnt                          <= r_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_sbox_sched.sv
// ============================================================================
// Module      : tb_aes_sbox_sched
// Description : Self-checking bench for aes_sbox_sched. A transaction-level
//               reference model (GF(2^8) S-box, round-robin pick by search,
//               fixed 5-cycle response latency) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_sbox_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [32*NREQ-1:0]  req_word = '0;
    logic [NREQ-1:0]     req_ready;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [31:0]         resp_word;
    logic [IDW-1:0]      resp_id;
    logic                busy;

    aes_sbox_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_word   (req_word),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_word  (resp_word),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox(w[8*k +: 8]);
        return r;
    endfunction

    // Who wins given the pending set and the last round-robin grant.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int i;
`ifdef AES_SBOX_SCHED_PRIO_EN
        if (v[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (i != 0 && v[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    bit          m_known   = 0;
    bit          m_pending = 0;
    bit          m_clear   = 0;
    int          m_acc     = 0;
    int          m_last    = NREQ - 1;
    int          m_id      = 0;
    logic [31:0] m_word    = '0;
    int          cyc       = 0;

    int          grant_q[$];
    int          resp_id_q[$];
    int          resp_cyc_q[$];
    logic [31:0] resp_word_q[$];

    logic                drv_rst   = 1'b0;
    logic [NREQ-1:0]     drv_valid = '0;
    logic [32*NREQ-1:0]  drv_word  = '0;
    logic                drv_rr    = 1'b1;

    // One clock: apply inputs after the edge, check mid-cycle, then advance the model.
    task automatic run_cycle();
        logic [NREQ-1:0] exp_ready;
        bit              exp_rv, exp_busy;
        int              g;
        @(posedge clk); #1;
        rst = drv_rst; req_valid = drv_valid; req_word = drv_word; resp_ready = drv_rr;
        @(negedge clk);
        cyc++;
        exp_ready = '0;
        g = -1;
        if (!m_pending) begin
            g = pick(req_valid, m_last);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        exp_rv   = m_pending && (cyc >= m_acc + 5);
        exp_busy = m_pending && (cyc >= m_acc + 1);
        if (m_known) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("busy", 32'(busy), 32'(exp_busy));
            if (exp_rv) begin
                check("resp_word", resp_word, m_word);
                check("resp_id", 32'(resp_id), 32'(m_id));
            end
            if (m_clear) begin
                check("clr_word", resp_word, 32'h0);
                check("clr_id", 32'(resp_id), 32'h0);
            end
        end
        if (!rst) begin
            m_known = 1; m_pending = 0; m_clear = 1; m_last = NREQ - 1;
        end else begin
            if (exp_rv && resp_ready) begin
                m_pending = 0;
                resp_id_q.push_back(m_id);
                resp_cyc_q.push_back(cyc);
                resp_word_q.push_back(m_word);
            end
            if (g >= 0) begin
                m_pending = 1; m_clear = 0; m_acc = cyc; m_id = g;
                m_word = sbox_word(req_word[32*g +: 32]);
`ifdef AES_SBOX_SCHED_PRIO_EN
                if (g != 0) m_last = g;
`else
                m_last = g;
`endif
                grant_q.push_back(g);
            end
        end
    endtask

    task automatic idle_until_free();
        int n;
        n = 0;
        while (m_pending && n < 40) begin
            run_cycle();
            n++;
        end
        if (m_pending) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        drv_rst = 1'b0; drv_valid = '0;
        run_cycle();
        drv_rst = 1'b1;
        grant_q.delete(); resp_id_q.delete(); resp_cyc_q.delete(); resp_word_q.delete();
    endtask

    // One request from a single requester; returns the substituted word seen at handshake.
    task automatic single(input int id, input logic [31:0] w, output logic [31:0] got);
        int acc_cyc;
        drv_rr = 1'b1;
        drv_valid = '0; drv_valid[id] = 1'b1;
        drv_word[32*id +: 32] = w;
        run_cycle();
        acc_cyc = cyc;
        check("single_ready", 32'(req_ready), 32'(1) << id);
        drv_valid = '0;
        idle_until_free();
        got = 32'hdeadbeef;
        if (resp_word_q.size() > 0) begin
            got = resp_word_q[$];
            check("single_latency", 32'(resp_cyc_q[$] - acc_cyc), 32'd5);
        end
    endtask

    logic [31:0] got_w, snap_w;
    logic [IDW-1:0] snap_id;
    int n0, guard;
    int exp_seq[6];
    int exp_pri[4];

    initial begin
        // Reset and idle state.
        drv_rst = 1'b0;
        repeat (3) run_cycle();
        drv_rst = 1'b1;
        run_cycle();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_word", resp_word, 32'h0);
        check("rst_resp_id", 32'(resp_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Value corners.
        single(0, 32'h00010203, got_w); check("vec_0123", got_w, 32'h637c777b);
        single(1, 32'hffffffff, got_w); check("vec_ff", got_w, 32'h16161616);
        single(2, 32'h52525252, got_w); check("vec_52", got_w, 32'h00000000);
        single(3, 32'h53c8e1ff, got_w); check("vec_53c8", got_w, sbox_word(32'h53c8e1ff));

        // Fairness with everyone pending.
        do_reset();
        drv_valid = '1; drv_rr = 1'b1;
        drv_word = {$urandom(), $urandom(), $urandom(), $urandom()};
        guard = 0;
        while (resp_id_q.size() < 6 && guard < 80) begin run_cycle(); guard++; end
        drv_valid = '0;
        idle_until_free();
`ifdef AES_SBOX_SCHED_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 0, 0};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1};
`endif
        if (resp_id_q.size() < 6) check("fair_timeout", 32'd1, 32'd0);
        else begin
            for (int i = 0; i < 6; i++) check("fair_id", 32'(resp_id_q[i]), 32'(exp_seq[i]));
            for (int i = 1; i < 6; i++) check("fair_interval", 32'(resp_cyc_q[i] - resp_cyc_q[i-1]), 32'd6);
        end

        // Backpressure in RESP with all requesters pending.
        drv_rr = 1'b0;
        drv_valid = 4'b0100;
        drv_word[64 +: 32] = $urandom();
        run_cycle();
        drv_valid = '1;
        repeat (5) run_cycle();
        snap_w = resp_word; snap_id = resp_id;
        check("bp_enter_valid", 32'(resp_valid), 32'd1);
        n0 = resp_id_q.size();
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_word", resp_word, snap_w);
            check("bp_id", 32'(resp_id), 32'(snap_id));
            check("bp_ready", 32'(req_ready), 32'h0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        drv_rr = 1'b1; drv_valid = '0;
        run_cycle();
        check("bp_handshake", 32'(resp_id_q.size() - n0), 32'd1);
        run_cycle();
        check("bp_valid_drop", 32'(resp_valid), 32'd0);

        // Reset in the middle of an operation.
        drv_valid = 4'b0010;
        drv_word[32 +: 32] = $urandom();
        run_cycle();
        drv_valid = '0;
        run_cycle();
        drv_rst = 1'b0;
        run_cycle();
        drv_rst = 1'b1;
        run_cycle();
        check("mid_rst_valid", 32'(resp_valid), 32'h0);
        check("mid_rst_word", resp_word, 32'h0);
        check("mid_rst_id", 32'(resp_id), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        n0 = resp_id_q.size();
        repeat (8) run_cycle();
        check("mid_rst_no_resp", 32'(resp_id_q.size()), 32'(n0));
        drv_valid = '1;
        run_cycle();
        check("mid_rst_grant0", 32'(req_ready), 32'h1);
        drv_valid = '0;
        idle_until_free();

        // Requesters 0 and 1 competing.
        do_reset();
        drv_valid = 4'b0011; drv_rr = 1'b1;
        guard = 0;
        while (grant_q.size() < 4 && guard < 60) begin run_cycle(); guard++; end
        drv_valid = '0;
        idle_until_free();
`ifdef AES_SBOX_SCHED_PRIO_EN
        exp_pri = '{0, 0, 0, 0};
`else
        exp_pri = '{0, 1, 0, 1};
`endif
        if (grant_q.size() < 4) check("prio_timeout", 32'd1, 32'd0);
        else for (int i = 0; i < 4; i++) check("prio_grant", 32'(grant_q[i]), 32'(exp_pri[i]));

        // Random traffic, backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            drv_valid = NREQ'($urandom_range(0, 15));
            drv_word  = {$urandom(), $urandom(), $urandom(), $urandom()};
            drv_rr    = ($urandom_range(0, 9) < 7);
            drv_rst   = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            run_cycle();
        end
        drv_rst = 1'b1; drv_valid = '0; drv_rr = 1'b1;
        idle_until_free();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
